// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low segment lookup.
// A blanked digit drives every segment off regardless of the nibble.
module hex_seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG[nibble_i];
        if (blank_i) begin
            seg_o = SEG_OFF;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode, active-low 7-segment bank.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           data_in,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [2:0]            digit_idx,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("display_scan_ctrl: NUM_DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("display_scan_ctrl: REFRESH_DIV must be >= 2");
    end

    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           active_q, active_d;
    logic [31:0]           pending_q, pending_d;
    logic                  pending_vld_q, pending_vld_d;
    logic                  frame_tick_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;

    logic                  term_cnt;
    logic                  frame_end;
    logic                  accept;
    logic [3:0]            cur_nibble;
    logic                  blank;
    logic [6:0]            seg_dec;

`ifdef DISP_LZ_BLANK_EN
    // A digit is blank when it and every higher displayed digit are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [31:0] val, input logic [2:0] idx);
        logic higher_nz;
        higher_nz = 1'b0;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (3'(j) == idx) begin
                return (val[j*4 +: 4] == 4'd0) && !higher_nz;
            end
            higher_nz = higher_nz | (val[j*4 +: 4] != 4'd0);
        end
        return 1'b0;
    endfunction
`endif

    always_comb begin
        term_cnt   = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
        frame_end  = term_cnt && (idx_q == 3'(NUM_DIGITS - 1));
        accept     = load_valid && !pending_vld_q;
        cur_nibble = active_q[{idx_q, 2'b00} +: 4];
`ifdef DISP_LZ_BLANK_EN
        blank      = lz_blank(active_q, idx_q);
`else
        blank      = 1'b0;
`endif

        div_cnt_d = term_cnt ? '0 : div_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (term_cnt) begin
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end

        // New values only reach the active register at a frame boundary.
        active_d      = active_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        if (frame_end && pending_vld_q) begin
            active_d      = pending_q;
            pending_vld_d = 1'b0;
        end else if (accept && frame_end) begin
            active_d = data_in;
        end else if (accept) begin
            pending_d     = data_in;
            pending_vld_d = 1'b1;
        end

        // All anodes off during the terminal count to avoid ghosting into the next digit.
        anodes_d = term_cnt ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end

    hex_seg_decode u_decode (
        .nibble_i (cur_nibble),
        .blank_i  (blank),
        .seg_o    (seg_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q     <= '0;
            idx_q         <= 3'd0;
            active_q      <= '0;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            seg_q         <= SEG_OFF;
            anodes_q      <= '1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            frame_tick_q  <= frame_end;
            seg_q         <= seg_dec;
            anodes_q      <= anodes_d;
        end
    end

    assign load_ready = !pending_vld_q;
    assign segments   = seg_q;
    assign anodes     = anodes_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a shared, active-low, common-anode 7-segment display bank.
- Displays NUM_DIGITS hex nibbles of a 32-bit register-file value.
- Accepts new values through a valid/ready handshake and swaps them in only at frame boundaries, so no frame is ever torn.
- Sits between the register file readout and the board display pins.

Parameters:
NUM_DIGITS, 4, digits scanned (legal 1..8; elaboration error outside range)
REFRESH_DIV, 50000, clock cycles each digit stays lit (legal >= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_valid  in  1  data_in is offered this cycle
load_ready  out  1  pending slot empty; value accepted when load_valid && load_ready
data_in  in  32  value to display; digit i shows nibble data_in[4i+3:4i]
segments  out  7  segment pattern {g,f,e,d,c,b,a}, active low
anodes  out  NUM_DIGITS  digit enables, active low, one-hot-low
digit_idx  out  3  index of the digit currently driven
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset values (asynchronous): segments=7'h7F, anodes all 1, digit_idx=0, frame_tick=0, load_ready=1. Internal: div_cnt=0, active value=0, pending empty.
- Reset asserted mid-scan or with a value pending: all state clears immediately and the pending value is discarded.
- div_cnt counts 0..REFRESH_DIV-1. At terminal count, div_cnt returns to 0 and digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- frame_tick is registered. It is 1 exactly in the cycle after digit_idx changes from NUM_DIGITS-1 to 0.
- Frame boundary = the terminal-count cycle with digit_idx==NUM_DIGITS-1.
- Handshake:
  - load_ready = !pending_valid.
  - Accepted value goes to the pending register.
  - At a frame boundary, a pending value moves to active and pending clears.
  - Accept and frame boundary in the same cycle with pending empty: data_in goes directly to active; pending stays empty; load_ready stays 1.
  - load_valid while load_ready=0 is ignored; data is not captured.
- Outputs are registered from digit_idx and active:
  - anodes: bit digit_idx = 0, all others 1.
  - segments = decode(active nibble[digit_idx]).
  - Latency is 1 cycle after a digit_idx or active change.
- Anti-ghosting: in the terminal-count cycle, anodes are driven all 1 for one cycle before the next digit lights.
- Hex decode, active low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Nibbles above NUM_DIGITS are never shown.

Optional Feature:
DISP_LZ_BLANK_EN
- Defined: leading-zero blanking. Digit i shows segments=7'h7F (its anode still pulses) when the nibble is 0 and all higher displayed nibbles are 0. Digit 0 is never blanked, so value 0 shows "0".
- Undefined: every digit is always decoded, zeros included.

Decomposition:
- Package disp_pkg: SEG_OFF=7'h7F constant, the 16-entry hex-to-segment constant table, seg_t typedef (logic [6:0]).
- One sub-module, hex_seg_decode: combinational nibble -> seg_t lookup with a blank input.
- Counter, scan, handshake and output registers stay in the top module.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4; reset, release, no load -> anodes cycle 1110,1101,1011,0111 every 4 cycles; segments=1000000 while lit; frame_tick pulses every 16 cycles.
- Load 0x0000_1234 mid-frame -> load_ready drops to 0; after the next frame_tick, digits 0..3 show 0011001, 0110000, 0100100, 1111001; load_ready returns to 1.
- Load 0xABCD, then offer 0x5555 while load_ready=0 -> 0x5555 is ignored; the display shows d, C, b, A.
- load_valid asserted with 0xFFFF in the frame-boundary cycle with pending empty -> the next frame shows F on all digits (0001110); load_ready never drops.
- Assert reset during digit 2 with a pending value -> anodes=1111 and segments=7'h7F immediately; after release the display shows 0 on all digits.
- DISP_LZ_BLANK_EN defined, load 0x0000_0070 -> digits 3 and 2 show 1111111, digit 1 shows 1111000, digit 0 shows 1000000.
